// File: rtl/pixel_frame_store_pkg.sv
// pixel_frame_store_pkg
//   Shared types and helpers for the pixel frame store:
//   - command opcode enum and its bus width
//   - control FSM state enum
//   - decode of the raw opcode field and the per-pixel draw operation
package pixel_frame_store_pkg;

    localparam int OP_W      = 3;
    localparam int PIX_MAX_W = 32;   // widest pixel the draw helper handles

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_OR    = 3'd2,
        OP_ANDN  = 3'd3,
        OP_XOR   = 3'd4
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Codes 5-7 have no draw meaning and behave as a plain read.
    function automatic op_e decode_op(input logic [OP_W-1:0] raw);
        case (raw)
            3'd1:    return OP_WRITE;
            3'd2:    return OP_OR;
            3'd3:    return OP_ANDN;
            3'd4:    return OP_XOR;
            default: return OP_READ;
        endcase
    endfunction

    // Bitwise ops only, so callers may zero-extend narrower pixels and
    // truncate the result back without affecting the low bits.
    function automatic logic [PIX_MAX_W-1:0] apply_op(
        input op_e                  op,
        input logic [PIX_MAX_W-1:0] old_px,
        input logic [PIX_MAX_W-1:0] data_px
    );
        case (op)
            OP_WRITE: return data_px;
            OP_OR:    return old_px | data_px;
            OP_ANDN:  return old_px & ~data_px;
            OP_XOR:   return old_px ^ data_px;
            default:  return old_px;
        endcase
    endfunction

endpackage

// File: rtl/pixel_frame_store_if.sv
// pixel_frame_store_if
//   Command, read-return, clear-control and video signals of the frame store.
//   master: drives CMD_VALID/CMD_OP/CMD_X/CMD_Y/CMD_DATA, CLR_START, VID_ADDR
//   slave : drives CMD_READY, RD_VALID/RD_DATA, BUSY, VID_DATA, CLIP_ERR
interface pixel_frame_store_if
    import pixel_frame_store_pkg::*;
#(
    parameter int PIXEL_W = 1,
    parameter int X_BITS  = 8,
    parameter int Y_BITS  = 7
);
    logic                     CMD_VALID;
    logic                     CMD_READY;
    logic [OP_W-1:0]          CMD_OP;
    logic [X_BITS-1:0]        CMD_X;
    logic [Y_BITS-1:0]        CMD_Y;
    logic [PIXEL_W-1:0]       CMD_DATA;
    logic                     RD_VALID;
    logic [PIXEL_W-1:0]       RD_DATA;
    logic                     CLR_START;
    logic                     BUSY;
    logic [X_BITS+Y_BITS-1:0] VID_ADDR;
    logic [PIXEL_W-1:0]       VID_DATA;
    logic                     CLIP_ERR;

    modport master (
        output CMD_VALID, CMD_OP, CMD_X, CMD_Y, CMD_DATA, CLR_START, VID_ADDR,
        input  CMD_READY, RD_VALID, RD_DATA, BUSY, VID_DATA, CLIP_ERR
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_X, CMD_Y, CMD_DATA, CLR_START, VID_ADDR,
        output CMD_READY, RD_VALID, RD_DATA, BUSY, VID_DATA, CLIP_ERR
    );
endinterface

// File: rtl/pixel_frame_store_ram.sv
// pixel_frame_store_ram
//   Single-clock true dual-port RAM, read-first on both ports, no reset.
//   Port A: read/write (a_we_i, a_addr_i, a_wdata_i -> a_rdata_o)
//   Port B: read-only  (b_addr_i -> b_rdata_o)
//   Read data is registered: one clock of latency.
module pixel_frame_store_ram #(
    parameter int WIDTH  = 1,
    parameter int ADDR_W = 15
) (
    input  logic              clk_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [WIDTH-1:0]  a_wdata_i,
    output logic [WIDTH-1:0]  a_rdata_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [WIDTH-1:0]  b_rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    // Non-blocking write means reads in the same edge see the old word.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        a_rdata_o <= mem_q[a_addr_i];
        b_rdata_o <= mem_q[b_addr_i];
    end
endmodule

// File: rtl/pixel_frame_store.sv
// pixel_frame_store
//   N-bit pixel frame buffer with a pipelined draw-command port, a hardware
//   clear engine and an independent read-only video port.
//   Ports: CLK, RESETN (async, active low), bus (pixel_frame_store_if.slave).
//   Optional build macro PIXEL_FRAME_STORE_CLIP_EN: commands outside
//   FRAME_W x FRAME_H touch no memory, return 0 and pulse CLIP_ERR.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | accepting commands, one per cycle
//   ST_CLEAR | writing CLEAR_VALUE to every address, commands stalled
module pixel_frame_store
    import pixel_frame_store_pkg::*;
#(
    parameter int                 PIXEL_W     = 1,
    parameter int                 X_BITS      = 8,
    parameter int                 Y_BITS      = 7,
    parameter logic [PIXEL_W-1:0] CLEAR_VALUE = '0,
    parameter int                 FRAME_W     = 256,
    parameter int                 FRAME_H     = 128
) (
    input  logic                CLK,
    input  logic                RESETN,
    pixel_frame_store_if.slave  bus
);
    localparam int              ADDR_W    = X_BITS + Y_BITS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic                s2_vld_q, s2_clip_q;
    op_e                 s2_op_q;
    logic [ADDR_W-1:0]   s2_addr_q;
    logic [PIXEL_W-1:0]  s2_data_q;
    logic                fwd_sel_q;
    logic [PIXEL_W-1:0]  fwd_data_q;

    logic                rd_valid_q, clip_err_q, vid_vld_q;
    logic [PIXEL_W-1:0]  rd_data_q;

    logic                accept, cmd_clip, s2_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [PIXEL_W-1:0]  old_px, new_px, cmd_rdata, vid_rdata;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIXEL_W-1:0]  wr_data;
    logic [PIXEL_W-1:0]  unused_cmd_a_rdata, unused_vid_a_rdata;

    assign cmd_addr = {bus.CMD_Y, bus.CMD_X};
    assign accept   = bus.CMD_VALID && bus.CMD_READY;

`ifdef PIXEL_FRAME_STORE_CLIP_EN
    assign cmd_clip = (int'(bus.CMD_X) >= FRAME_W) || (int'(bus.CMD_Y) >= FRAME_H);
`else
    localparam int unused_frame_dims = FRAME_W + FRAME_H;
    assign cmd_clip = 1'b0;   // keeps s2_clip_q, and so CLIP_ERR, at 0
`endif

    // Stage 2: the memory word read when the command was accepted is stale
    // if the previous command wrote the same address at that same edge.
    assign old_px = fwd_sel_q ? fwd_data_q : cmd_rdata;
    assign new_px = PIXEL_W'(apply_op(s2_op_q, PIX_MAX_W'(old_px), PIX_MAX_W'(s2_data_q)));
    assign s2_we  = s2_vld_q && !s2_clip_q && (s2_op_q != OP_READ);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_en     = 1'b0;
        wr_addr   = s2_addr_q;
        wr_data   = new_px;
        case (state_q)
            ST_IDLE: begin
                wr_en = s2_we;
                if (bus.CLR_START) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                wr_data   = CLEAR_VALUE;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_clip_q  <= 1'b0;
            s2_op_q    <= OP_READ;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            clip_err_q <= 1'b0;
            vid_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            vid_vld_q  <= 1'b1;
            s2_vld_q   <= accept;
            if (accept) begin
                s2_op_q    <= decode_op(bus.CMD_OP);
                s2_addr_q  <= cmd_addr;
                s2_data_q  <= bus.CMD_DATA;
                s2_clip_q  <= cmd_clip;
                fwd_sel_q  <= s2_we && (s2_addr_q == cmd_addr);
                fwd_data_q <= new_px;
            end
            rd_valid_q <= s2_vld_q;
            clip_err_q <= s2_vld_q && s2_clip_q;
            if (s2_vld_q) begin
                rd_data_q <= s2_clip_q ? '0 : old_px;
            end
        end
    end

    // Two identical copies, written together, give the command pipeline and
    // the video scan-out each an independent read port.
    pixel_frame_store_ram #(.WIDTH(PIXEL_W), .ADDR_W(ADDR_W)) u_ram_cmd (
        .clk_i     (CLK),
        .a_we_i    (wr_en),
        .a_addr_i  (wr_addr),
        .a_wdata_i (wr_data),
        .a_rdata_o (unused_cmd_a_rdata),
        .b_addr_i  (cmd_addr),
        .b_rdata_o (cmd_rdata)
    );

    pixel_frame_store_ram #(.WIDTH(PIXEL_W), .ADDR_W(ADDR_W)) u_ram_vid (
        .clk_i     (CLK),
        .a_we_i    (wr_en),
        .a_addr_i  (wr_addr),
        .a_wdata_i (wr_data),
        .a_rdata_o (unused_vid_a_rdata),
        .b_addr_i  (bus.VID_ADDR),
        .b_rdata_o (vid_rdata)
    );

    assign bus.CMD_READY = (state_q == ST_IDLE) && !bus.CLR_START;
    assign bus.BUSY      = (state_q == ST_CLEAR);
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.CLIP_ERR  = clip_err_q;
    // RAM output has no reset; hold VID_DATA at 0 until it has been loaded.
    assign bus.VID_DATA  = vid_vld_q ? vid_rdata : '0;
endmodule

// File: tb/tb_pixel_frame_store.sv
// tb_pixel_frame_store
//   Directed bench for pixel_frame_store: a 1-bit 256x128 instance (main)
//   and a 4-bit 8x4 instance (small) sharing clock and reset.
module tb_pixel_frame_store;
    import pixel_frame_store_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pixel_frame_store_if #(.PIXEL_W(1), .X_BITS(8), .Y_BITS(7)) bus_m ();
    pixel_frame_store_if #(.PIXEL_W(4), .X_BITS(3), .Y_BITS(2)) bus_s ();

    pixel_frame_store #(
        .PIXEL_W(1), .X_BITS(8), .Y_BITS(7), .CLEAR_VALUE(1'b0),
        .FRAME_W(160), .FRAME_H(128)
    ) u_dut_m (.CLK(clk), .RESETN(rst_n), .bus(bus_m));

    pixel_frame_store #(
        .PIXEL_W(4), .X_BITS(3), .Y_BITS(2), .CLEAR_VALUE(4'h0),
        .FRAME_W(8), .FRAME_H(4)
    ) u_dut_s (.CLK(clk), .RESETN(rst_n), .bus(bus_s));

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] rdq_m[$];
    logic       clq_m[$];
    logic [3:0] rdq_s[$];
    int         clip_stray = 0;

    always @(negedge clk) begin
        if (bus_m.RD_VALID) begin
            rdq_m.push_back({3'b000, bus_m.RD_DATA});
            clq_m.push_back(bus_m.CLIP_ERR);
        end
        if (bus_m.CLIP_ERR && !bus_m.RD_VALID) clip_stray++;
        if (bus_s.RD_VALID) rdq_s.push_back(bus_s.RD_DATA);
    end

    task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cmd_m(input logic [2:0] op, input int x, input int y, input logic d);
        bus_m.CMD_VALID = 1'b1;
        bus_m.CMD_OP    = op;
        bus_m.CMD_X     = 8'(x);
        bus_m.CMD_Y     = 7'(y);
        bus_m.CMD_DATA  = d;
        @(negedge clk);
    endtask

    task automatic cmd_s(input logic [2:0] op, input int x, input int y, input logic [3:0] d);
        bus_s.CMD_VALID = 1'b1;
        bus_s.CMD_OP    = op;
        bus_s.CMD_X     = 3'(x);
        bus_s.CMD_Y     = 2'(y);
        bus_s.CMD_DATA  = d;
        @(negedge clk);
    endtask

    task automatic idle_m(input int n);
        bus_m.CMD_VALID = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_s(input int n);
        bus_s.CMD_VALID = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int  busy_n;
        logic ready_bad;

        bus_m.CMD_VALID = 0; bus_m.CMD_OP = 0; bus_m.CMD_X = 0; bus_m.CMD_Y = 0;
        bus_m.CMD_DATA = 0; bus_m.CLR_START = 0; bus_m.VID_ADDR = 0;
        bus_s.CMD_VALID = 0; bus_s.CMD_OP = 0; bus_s.CMD_X = 0; bus_s.CMD_Y = 0;
        bus_s.CMD_DATA = 0; bus_s.CLR_START = 0; bus_s.VID_ADDR = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_vec("rst_rd_valid", bus_m.RD_VALID, 0);
        chk_vec("rst_rd_data",  bus_m.RD_DATA, 0);
        chk_vec("rst_busy",     bus_m.BUSY, 0);
        chk_vec("rst_clip_err", bus_m.CLIP_ERR, 0);
        chk_vec("rst_vid_data", bus_m.VID_DATA, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_vec("rst_ready", bus_m.CMD_READY, 1);

        // WRITE then READ of (5,3): result 2 edges after each acceptance
        cmd_m(OP_WRITE, 5, 3, 1'b1);
        chk_vec("wr_lat_early", bus_m.RD_VALID, 0);
        cmd_m(OP_READ, 5, 3, 1'b0);
        chk_vec("wr_rd_valid", bus_m.RD_VALID, 1);
        idle_m(1);
        chk_vec("rd_rd_valid", bus_m.RD_VALID, 1);
        chk_vec("rd_rd_data",  bus_m.RD_DATA, 1);
        bus_m.VID_ADDR = {7'd3, 8'd5};
        @(negedge clk);
        chk_vec("rd_pulse_end", bus_m.RD_VALID, 0);
        chk_vec("vid_5_3",      bus_m.VID_DATA, 1);

        // Back-to-back XOR accumulation through forwarding; op 7 acts as READ
        idle_m(2);
        rdq_m.delete(); clq_m.delete();
        cmd_m(OP_WRITE, 10, 10, 1'b0);
        repeat (3) cmd_m(OP_XOR, 10, 10, 1'b1);
        cmd_m(OP_READ, 10, 10, 1'b0);
        cmd_m(3'd7, 10, 10, 1'b1);
        cmd_m(OP_READ, 10, 10, 1'b0);
        idle_m(4);
        chk_vec("xor_count", rdq_m.size(), 7);
        chk_vec("xor_1", rdq_m[1], 0);
        chk_vec("xor_2", rdq_m[2], 1);
        chk_vec("xor_3", rdq_m[3], 0);
        chk_vec("xor_rd", rdq_m[4], 1);
        chk_vec("op7_rd", rdq_m[5], 1);
        chk_vec("op7_nowr", rdq_m[6], 1);

        // 4-bit pixel: WRITE A, OR 5, ANDN 3, XOR F, READ on (2,1)
        rdq_s.delete();
        cmd_s(OP_WRITE, 2, 1, 4'hA);
        cmd_s(OP_OR,    2, 1, 4'h5);
        cmd_s(OP_ANDN,  2, 1, 4'h3);
        cmd_s(OP_XOR,   2, 1, 4'hF);
        cmd_s(OP_READ,  2, 1, 4'h0);
        idle_s(4);
        chk_vec("w4_count", rdq_s.size(), 5);
        chk_vec("w4_write", rdq_s[1], 4'hA);
        chk_vec("w4_or",    rdq_s[2], 4'hF);
        chk_vec("w4_andn",  rdq_s[3], 4'hC);
        chk_vec("w4_xor",   rdq_s[4], 4'h3);
        bus_s.VID_ADDR = {2'd1, 3'd2};
        @(negedge clk);
        chk_vec("w4_vid", bus_s.VID_DATA, 4'h3);

        // Small clear: fill with F, clear wins over a same-cycle command,
        // CLR_START during clear ignored, exact duration 32 cycles
        for (int i = 0; i < 32; i++) cmd_s(OP_WRITE, i % 8, i / 8, 4'hF);
        idle_s(3);
        bus_s.VID_ADDR = 5'd17;
        @(negedge clk);
        chk_vec("fill_vid", bus_s.VID_DATA, 4'hF);
        rdq_s.delete();
        bus_s.CLR_START = 1'b1;
        bus_s.CMD_VALID = 1'b1; bus_s.CMD_OP = OP_WRITE; bus_s.CMD_DATA = 4'h5;
        bus_s.CMD_X = 3'd0; bus_s.CMD_Y = 2'd0;
        #1;
        chk_vec("clr_beats_cmd", bus_s.CMD_READY, 0);
        @(negedge clk);
        bus_s.CLR_START = 1'b0;
        bus_s.CMD_VALID = 1'b0;
        busy_n = 0; ready_bad = 1'b0;
        while (bus_s.BUSY && busy_n < 100) begin
            busy_n++;
            if (bus_s.CMD_READY) ready_bad = 1'b1;
            bus_s.CLR_START = (busy_n == 10);
            @(negedge clk);
        end
        bus_s.CLR_START = 1'b0;
        chk_vec("s_busy_cycles", busy_n, 32);
        chk_vec("s_ready_in_clr", ready_bad, 0);
        idle_s(3);
        chk_vec("s_clr_no_accept", rdq_s.size(), 0);
        for (int i = 0; i < 32; i++) begin
            bus_s.VID_ADDR = 5'(i);
            @(negedge clk);
            chk_vec($sformatf("s_vid_clr_%0d", i), bus_s.VID_DATA, 0);
        end

        // Full-size clear: 32768 cycles, restart attempt mid-way ignored
        rdq_m.delete(); clq_m.delete();
        bus_m.CLR_START = 1'b1;
        bus_m.CMD_VALID = 1'b1; bus_m.CMD_OP = OP_WRITE; bus_m.CMD_DATA = 1'b1;
        bus_m.CMD_X = 8'd7; bus_m.CMD_Y = 7'd7;
        #1;
        chk_vec("m_clr_beats_cmd", bus_m.CMD_READY, 0);
        @(negedge clk);
        bus_m.CLR_START = 1'b0;
        bus_m.CMD_VALID = 1'b0;
        busy_n = 0; ready_bad = 1'b0;
        while (bus_m.BUSY && busy_n < 40000) begin
            busy_n++;
            if (bus_m.CMD_READY) ready_bad = 1'b1;
            bus_m.CLR_START = (busy_n == 1000);
            @(negedge clk);
        end
        bus_m.CLR_START = 1'b0;
        chk_vec("m_busy_cycles", busy_n, 32768);
        chk_vec("m_ready_in_clr", ready_bad, 0);
        idle_m(3);
        chk_vec("m_clr_no_accept", rdq_m.size(), 0);
        bus_m.VID_ADDR = {7'd3, 8'd5};
        @(negedge clk);
        chk_vec("m_vid_clr_5_3", bus_m.VID_DATA, 0);
        bus_m.VID_ADDR = {7'd10, 8'd10};
        @(negedge clk);
        chk_vec("m_vid_clr_10_10", bus_m.VID_DATA, 0);
        bus_m.VID_ADDR = {7'd7, 8'd7};
        @(negedge clk);
        chk_vec("m_vid_clr_7_7", bus_m.VID_DATA, 0);

        // Write outside the 160-wide visible area at x=200
        rdq_m.delete(); clq_m.delete();
        cmd_m(OP_WRITE, 200, 4, 1'b1);
        cmd_m(OP_READ,  200, 4, 1'b0);
        idle_m(4);
        bus_m.VID_ADDR = {7'd4, 8'd200};
        @(negedge clk);
        chk_vec("x200_count", rdq_m.size(), 2);
        chk_vec("x200_wr_data", rdq_m[0], 0);
`ifdef PIXEL_FRAME_STORE_CLIP_EN
        chk_vec("x200_wr_clip", clq_m[0], 1);
        chk_vec("x200_rd_data", rdq_m[1], 0);
        chk_vec("x200_rd_clip", clq_m[1], 1);
        chk_vec("x200_vid", bus_m.VID_DATA, 0);
`else
        chk_vec("x200_wr_clip", clq_m[0], 0);
        chk_vec("x200_rd_data", rdq_m[1], 1);
        chk_vec("x200_rd_clip", clq_m[1], 0);
        chk_vec("x200_vid", bus_m.VID_DATA, 1);
`endif
        chk_vec("clip_stray", clip_stray, 0);

        // Reset in the middle of a clear
        bus_m.CLR_START = 1'b1;
        @(negedge clk);
        bus_m.CLR_START = 1'b0;
        repeat (50) @(negedge clk);
        chk_vec("midclr_busy", bus_m.BUSY, 1);
        rst_n = 1'b0;
        #1;
        chk_vec("midclr_rst_busy", bus_m.BUSY, 0);
        chk_vec("midclr_rst_ready", bus_m.CMD_READY, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_vec("midclr_after", bus_m.BUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
